cpu7_ifu_fcl: RTL

//  Fetch control logic for the IFU fetch datapath. Generates the four active-low PC-before-fetch
//  mux selects (init / old / pcinc / brpc) and drives the icache request/cancel handshake.

---
 rtl/cpu7_ifu_fcl_if.sv | 35 +++
 rtl/cpu7_ifu_fcl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_fcl_if.sv
// Fetch-control interface: icache handshake, redirect/backpressure inputs,
// PC-before-fetch mux selects and delivery/status outputs.
interface cpu7_ifu_fcl_if;
   logic        inst_addr_ok;
   logic        inst_valid;
   logic        br_cancel;
   logic        de_stall;
   logic        inst_req;
   logic        inst_cancel;
   logic        fcl_fdp_pcbf_sel_init_l;
   logic        fcl_fdp_pcbf_sel_old_l;
   logic        fcl_fdp_pcbf_sel_pcinc_l;
   logic        fcl_fdp_pcbf_sel_brpc_l;
   logic        fcl_port0_valid;
   logic        fcl_tmo_err;
   logic [31:0] fcl_fetch_cnt;

   // fetch control side
   modport master (
      input  inst_addr_ok, inst_valid, br_cancel, de_stall,
      output inst_req, inst_cancel,
      output fcl_fdp_pcbf_sel_init_l, fcl_fdp_pcbf_sel_old_l,
      output fcl_fdp_pcbf_sel_pcinc_l, fcl_fdp_pcbf_sel_brpc_l,
      output fcl_port0_valid, fcl_tmo_err, fcl_fetch_cnt
   );

   // icache / decode / datapath side
   modport slave (
      output inst_addr_ok, inst_valid, br_cancel, de_stall,
      input  inst_req, inst_cancel,
      input  fcl_fdp_pcbf_sel_init_l, fcl_fdp_pcbf_sel_old_l,
      input  fcl_fdp_pcbf_sel_pcinc_l, fcl_fdp_pcbf_sel_brpc_l,
      input  fcl_port0_valid, fcl_tmo_err, fcl_fetch_cnt
   );
endinterface

// File: rtl/cpu7_ifu_fcl.sv
// IFU fetch control: one outstanding icache request, wrong-path squash after
// br_cancel, decode throttling, PC-before-fetch select generation, fetch
// timeout monitor and delivered-instruction counter.
module cpu7_ifu_fcl #(
   parameter int TMO_W      = 8,
   parameter int TMO_CYCLES = 255
) (
   input  logic          clock,
   input  logic          reset,
   cpu7_ifu_fcl_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYCLES);
   localparam logic [TMO_W-1:0] TMO_MAX = '1;
   localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

   state_t           state, state_nxt;
   logic [TMO_W-1:0] timer, timer_nxt, timer_inc;
   logic             req, pv, tmo_hit;
   logic             s_init, s_old, s_pcinc, s_brpc;
   logic             tmo_err;
   logic [31:0]      fetch_cnt;

   assign timer_inc = (timer == TMO_MAX) ? timer : timer + TMO_ONE;
   // Timeout only counts while a response is owed (WAIT or DROP).
   assign tmo_hit   = ~reset & ((state == S_WAIT) | (state == S_DROP)) & (timer == TMO_LIM);

   // Next-state, timer and one-hot select/handshake decode.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      req       = 1'b0;
      pv        = 1'b0;
      s_init    = 1'b0;
      s_old     = 1'b1;
      s_pcinc   = 1'b0;
      s_brpc    = 1'b0;
      if (reset) begin
         s_init    = 1'b1;
         s_old     = 1'b0;
         state_nxt = S_REQ;
         timer_nxt = '0;
      end else begin
         case (state)
            S_REQ: begin
               req = ~bus.de_stall & ~bus.br_cancel;
               if (bus.br_cancel) begin
                  s_old  = 1'b0;
                  s_brpc = 1'b1;
               end else if (req & bus.inst_addr_ok) begin
                  state_nxt = S_WAIT;
                  timer_nxt = '0;
               end
            end
            S_WAIT: begin
               if (bus.inst_valid & ~bus.br_cancel) begin
                  pv      = 1'b1;
                  s_old   = 1'b0;
                  s_pcinc = 1'b1;
                  req     = ~bus.de_stall;
                  // Back-to-back: a new address accepted alongside the response.
                  if (req & bus.inst_addr_ok) timer_nxt = '0;
                  else                        state_nxt = S_REQ;
               end else if (bus.br_cancel) begin
                  s_old     = 1'b0;
                  s_brpc    = 1'b1;
                  // Without a same-cycle response the old one is still owed.
                  state_nxt = bus.inst_valid ? S_REQ : S_DROP;
               end else begin
                  timer_nxt = timer_inc;
               end
            end
            S_DROP: begin
               if (bus.br_cancel) begin
                  s_old  = 1'b0;
                  s_brpc = 1'b1;
               end
               if (bus.inst_valid) state_nxt = S_REQ;
               else                timer_nxt = timer_inc;
            end
            default: state_nxt = S_REQ;
         endcase
      end
   end

   // State and timeout timer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_REQ;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Sticky timeout flag and delivered-instruction counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_err   <= 1'b0;
         fetch_cnt <= 32'd0;
      end else begin
         if (tmo_hit) tmo_err   <= 1'b1;
         if (pv)      fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   assign bus.inst_req                 = req;
   assign bus.inst_cancel              = bus.br_cancel & ~reset;
   assign bus.fcl_fdp_pcbf_sel_init_l  = ~s_init;
   assign bus.fcl_fdp_pcbf_sel_old_l   = ~s_old;
   assign bus.fcl_fdp_pcbf_sel_pcinc_l = ~s_pcinc;
   assign bus.fcl_fdp_pcbf_sel_brpc_l  = ~s_brpc;
   assign bus.fcl_port0_valid          = pv;
   assign bus.fcl_tmo_err              = tmo_err;
   assign bus.fcl_fetch_cnt            = fetch_cnt;

endmodule
